// File: rtl/sw_conditioner.sv
// Push-button front end: sync, debounce, press pulse
// and optional auto-repeat for the clock-set buttons.
module sw_conditioner #(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned REPEAT_DLY   = 25000000,
  parameter int unsigned REPEAT_PER   = 5000000,
  parameter logic [2:0]  REPEAT_EN    = 3'b100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_sw,
  output logic [2:0] o_sw_level,
  output logic [2:0] o_sw_pulse,
  output logic [2:0] o_sw_hold
);

  localparam int unsigned RMAX =
    (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RPT
  } rpt_state_e;

  logic [2:0] s1;
  logic [2:0] s2;

  // two-flop synchroniser, polarity normalised so 1 = pressed
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ACTIVE_LOW ? ~i_sw : i_sw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_sw
    logic [DW-1:0] dcnt;
    logic          lvl;
    logic          toggle;
    logic          rise;
    logic          fall;
    rpt_state_e    state;
    rpt_state_e    state_n;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_n;
    logic          rpt_tick;
    logic          pulse;

    assign toggle = (s2[i] != lvl) && (dcnt == DB_LAST);
    assign rise   = toggle && !lvl;
    assign fall   = toggle && lvl;

    // accept a new level only after it has been stable long enough
    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt <= '0;
        lvl  <= 1'b0;
      end else if (s2[i] == lvl) begin
        dcnt <= '0;
      end else if (toggle) begin
        dcnt <= '0;
        lvl  <= ~lvl;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end

    // repeat state and interval counter
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_n;
        rcnt  <= rcnt_n;
      end
    end

    // repeat sequencing: initial delay, then periodic ticks
    always_comb begin
      state_n  = state;
      rcnt_n   = rcnt;
      rpt_tick = 1'b0;
      unique case (state)
        IDLE: begin
          if (rise && REPEAT_EN[i]) begin
            state_n = DELAY;
            rcnt_n  = '0;
          end
        end
        DELAY: begin
          if (fall) begin
            state_n = IDLE;
            rcnt_n  = '0;
          end else if (rcnt == DLY_LAST) begin
            rpt_tick = 1'b1;
            state_n  = RPT;
            rcnt_n   = '0;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
        RPT: begin
          if (fall) begin
            state_n = IDLE;
            rcnt_n  = '0;
          end else if (rcnt == PER_LAST) begin
            rpt_tick = 1'b1;
            rcnt_n   = '0;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          rcnt_n  = '0;
        end
      endcase
    end

    // registered pulse on press or repeat tick
    always_ff @(posedge clk) begin
      if (rst) begin
        pulse <= 1'b0;
      end else begin
        pulse <= rise || rpt_tick;
      end
    end

    assign o_sw_level[i] = lvl;
    assign o_sw_pulse[i] = pulse;
    assign o_sw_hold[i]  = (state == RPT);
  end

endmodule
